pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Registered successor to the combinational branch decoder. Owns the program counter (PC)
//  and evaluates the same jump/branch conditions. Adds a parametrised return-address stack
//  for CALL/CALLI/RET, latched multi-line interrupt pending bits, a stall input, and a
//  sticky stack-fault flag. Sits between instruction decode and fetch.
//  The fetch address is always the registered pc.
// PARAMETERS
//  WORD_WIDTH  32  width of top/second data operands
//  PC_WIDTH    16  program counter and target width
//  CALL_DEPTH  8   return-stack entries; must be a power of 2 and >= 2
//  INTERRUPTS  4   number of interrupt request lines
// PORTS
//  clk          in   1                        clock; all state updates on rising edge
//  reset        in   1                        synchronous, active-high reset
//  stall        in   1                        1 = hold pc/stack/fault this cycle
//  instruction  in   8                        opcode, same encoding as the instruction defs
//  immediate    in   PC_WIDTH                 absolute target for CALLI/JMPI; offset for branches
//  top, second  in   WORD_WIDTH               data-stack top and second
//  carry        in   1                        ALU carry flag
//  overflow     in   1                        ALU overflow flag
//  interrupt    in   INTERRUPTS               level/pulse requests, latched into pending
//  pc           out  PC_WIDTH                 current fetch address
//  taken        out  1                        registered: previous non-stalled instr redirected pc
//  call_depth   out  $clog2(CALL_DEPTH)+1     number of occupied stack entries
//  int_pending  out  INTERRUPTS               latched pending interrupt bits
//  stack_fault  out  1                        sticky overflow/underflow of the return stack
// BEHAVIOUR
//  - Reset: pc=0, taken=0, call_depth=0, int_pending=0, stack_fault=0, stack contents don't-care.
//    Reset mid-operation discards the stack and pending interrupts with no other side effect.
//  - Latency is 1 cycle. The instruction presented in cycle N (stall=0) sets pc/taken at edge N+1.
//  - next_pc defaults to pc+1, computed mod 2^PC_WIDTH.
//  - Branch conditions match the existing decoder: BRA, BC/BNC, BO/BNO, BEQ/BNE,
//    BLES/BLEQ (signed), BLESU/BLEQU (unsigned), BZ/BNZ.
//    * Taken target = pc + immediate, wrap mod 2^PC_WIDTH; immediate is treated as two's complement.
//  - BI is taken iff |int_pending. Taking BI clears the lowest set pending bit.
//    BNI is taken iff int_pending==0.
//  - JMPI: target = immediate. JMP: target = top[PC_WIDTH-1:0].
//  - CALLI/CALL: push pc+1, then jump to the same target as JMPI/JMP respectively.
//  - RET (new opcode I_RET): pop, then pc = popped value.
//  - CALL* when call_depth==CALL_DEPTH: no push, no jump (pc+1), stack_fault<=1, taken=0.
//  - RET when call_depth==0: no pop, pc+1, stack_fault<=1, taken=0.
//  - stack_fault clears only on reset.
//  - int_pending <= (int_pending & ~clear_mask) | interrupt, every cycle including stalled ones.
//    A new request on the same line as the bit being cleared stays pending (set wins).
//  - stall=1: pc, stack, call_depth, taken and stack_fault all hold. BI does not clear a pending bit.
//  - Unknown opcodes: pc+1, taken=0.
// STRUCTURE
//  - Shared package core0_flow_pkg holds:
//    * I_RET opcode constant
//    * a cond_t enum (ALWAYS, CARRY, OVF, INT, EQ, LTS, LES, LTU, LEU, ZERO), each with an invert bit
//    * a flow_kind_t enum (NONE, BRANCH, JUMP_IMM, JUMP_STK, CALL_IMM, CALL_STK, RET)
//  - Sub-module return_stack #(PC_WIDTH, CALL_DEPTH):
//    * ports: push, pop, push_data, top_data, depth, full, empty
//    * pointer-based register file; push and pop are never asserted together
//  - The top level contains decode, condition mux, pc register, pending logic and fault logic.
// TESTING
//  1. Reset then 3 NOPs -> pc steps 0,1,2,3; taken=0; call_depth=0.
//  2. pc=10, BEQ with top=second=5, immediate=-4 -> pc=6, taken=1.
//     Then BLES with second=-1, top=0 and immediate=2 -> pc=8.
//  3. CALLI imm=0x100 at pc=3, then RET -> pc=0x100 then 4; call_depth goes 1 then 0.
//  4. CALL_DEPTH+1 successive CALLIs -> last call: pc increments, stack_fault=1.
//     Then 9 RETs -> 8 valid returns, the 9th is a no-op; fault stays 1.
//  5. interrupt=4'b0110 pulse, then BI (taken, pending=0100), then BI with interrupt=4'b0100
//     in the same cycle -> taken, pending stays 0100. With pending=0, BNI -> taken.
//  6. stall=1 for 3 cycles with a JMPI and an interrupt pulse present -> pc unchanged,
//     pending updated. Deassert stall -> JMPI applies.
//     Assert reset mid-call-chain -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/core0_flow_pkg.sv
// Shared control-flow definitions: opcodes, branch conditions and the flow decode helper.
package core0_flow_pkg;

  localparam logic [7:0] I_NOP   = 8'h00;
  localparam logic [7:0] I_BRA   = 8'h10;
  localparam logic [7:0] I_BC    = 8'h11;
  localparam logic [7:0] I_BNC   = 8'h12;
  localparam logic [7:0] I_BO    = 8'h13;
  localparam logic [7:0] I_BNO   = 8'h14;
  localparam logic [7:0] I_BEQ   = 8'h15;
  localparam logic [7:0] I_BNE   = 8'h16;
  localparam logic [7:0] I_BLES  = 8'h17;
  localparam logic [7:0] I_BLEQ  = 8'h18;
  localparam logic [7:0] I_BLESU = 8'h19;
  localparam logic [7:0] I_BLEQU = 8'h1A;
  localparam logic [7:0] I_BZ    = 8'h1B;
  localparam logic [7:0] I_BNZ   = 8'h1C;
  localparam logic [7:0] I_BI    = 8'h1D;
  localparam logic [7:0] I_BNI   = 8'h1E;
  localparam logic [7:0] I_JMPI  = 8'h20;
  localparam logic [7:0] I_JMP   = 8'h21;
  localparam logic [7:0] I_CALLI = 8'h22;
  localparam logic [7:0] I_CALL  = 8'h23;
  localparam logic [7:0] I_RET   = 8'h24;

  typedef enum logic [3:0] {
    CondAlways, CondCarry, CondOvf, CondInt, CondEq,
    CondLts, CondLes, CondLtu, CondLeu, CondZero
  } cond_t;

  typedef enum logic [2:0] {
    FlowNone, FlowBranch, FlowJumpImm, FlowJumpStk, FlowCallImm, FlowCallStk, FlowRet
  } flow_kind_t;

  typedef struct packed {
    flow_kind_t kind;
    cond_t      cond;
    logic       inv;
  } flow_t;

  function automatic flow_t decode_flow(input logic [7:0] op);
    flow_t f;
    f.kind = FlowBranch;
    f.cond = CondAlways;
    f.inv  = 1'b0;
    case (op)
      I_BRA:   f.cond = CondAlways;
      I_BC:    f.cond = CondCarry;
      I_BNC:   begin f.cond = CondCarry; f.inv = 1'b1; end
      I_BO:    f.cond = CondOvf;
      I_BNO:   begin f.cond = CondOvf;   f.inv = 1'b1; end
      I_BEQ:   f.cond = CondEq;
      I_BNE:   begin f.cond = CondEq;    f.inv = 1'b1; end
      I_BLES:  f.cond = CondLts;
      I_BLEQ:  f.cond = CondLes;
      I_BLESU: f.cond = CondLtu;
      I_BLEQU: f.cond = CondLeu;
      I_BZ:    f.cond = CondZero;
      I_BNZ:   begin f.cond = CondZero;  f.inv = 1'b1; end
      I_BI:    f.cond = CondInt;
      I_BNI:   begin f.cond = CondInt;   f.inv = 1'b1; end
      I_JMPI:  f.kind = FlowJumpImm;
      I_JMP:   f.kind = FlowJumpStk;
      I_CALLI: f.kind = FlowCallImm;
      I_CALL:  f.kind = FlowCallStk;
      I_RET:   f.kind = FlowRet;
      default: f.kind = FlowNone;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/return_stack.sv
// Pointer-based return-address stack; the occupancy count doubles as the write pointer.
module return_stack #(
  parameter int unsigned PC_WIDTH   = 16,
  parameter int unsigned CALL_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [PC_WIDTH-1:0]           push_data,
  output logic [PC_WIDTH-1:0]           top_data,
  output logic [$clog2(CALL_DEPTH):0]   depth,
  output logic                          full,
  output logic                          empty
);

  localparam int unsigned AW = $clog2(CALL_DEPTH);
  localparam int unsigned DW = AW + 1;

  logic [PC_WIDTH-1:0] mem_q [CALL_DEPTH];
  logic [DW-1:0]       depth_q;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;

  assign wr_ptr   = depth_q[AW-1:0];
  assign rd_ptr   = wr_ptr - AW'(1);
  assign top_data = mem_q[rd_ptr];
  assign depth    = depth_q;
  assign full     = (depth_q == DW'(CALL_DEPTH));
  assign empty    = (depth_q == '0);

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
    end else if (push && !full) begin
      depth_q <= depth_q + DW'(1);
    end else if (pop && !empty) begin
      depth_q <= depth_q - DW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer: branch/jump/call/return decode, interrupt pending
// bits and a sticky return-stack fault flag.
module pc_sequencer
  import core0_flow_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned PC_WIDTH   = 16,
  parameter int unsigned CALL_DEPTH = 8,
  parameter int unsigned INTERRUPTS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [7:0]                   instruction,
  input  logic [PC_WIDTH-1:0]          immediate,
  input  logic [WORD_WIDTH-1:0]        top,
  input  logic [WORD_WIDTH-1:0]        second,
  input  logic                         carry,
  input  logic                         overflow,
  input  logic [INTERRUPTS-1:0]        interrupt,
  output logic [PC_WIDTH-1:0]          pc,
  output logic                         taken,
  output logic [$clog2(CALL_DEPTH):0]  call_depth,
  output logic [INTERRUPTS-1:0]        int_pending,
  output logic                         stack_fault
);

  flow_t                 flow;
  logic                  cond_raw;
  logic                  cond_ok;
  logic [PC_WIDTH-1:0]   pc_q, pc_d, pc_plus1, stk_target;
  logic                  taken_q, taken_d;
  logic                  fault_q, fault_d;
  logic [INTERRUPTS-1:0] pend_q, pend_d, pend_lowest, clear_mask;
  logic                  push, pop;
  logic [PC_WIDTH-1:0]   ret_addr;
  logic                  stk_full, stk_empty;
  logic                  unused_top_hi;

  assign flow          = decode_flow(instruction);
  assign pc_plus1      = pc_q + PC_WIDTH'(1);
  assign stk_target    = top[PC_WIDTH-1:0];
  assign unused_top_hi = ^top[WORD_WIDTH-1:PC_WIDTH];
  // Isolates the lowest set pending bit (two's-complement trick).
  assign pend_lowest   = pend_q & (~pend_q + INTERRUPTS'(1));

  always_comb begin
    cond_raw = 1'b0;
    case (flow.cond)
      CondAlways: cond_raw = 1'b1;
      CondCarry:  cond_raw = carry;
      CondOvf:    cond_raw = overflow;
      CondInt:    cond_raw = |pend_q;
      CondEq:     cond_raw = (top == second);
      CondLts:    cond_raw = ($signed(second) < $signed(top));
      CondLes:    cond_raw = ($signed(second) <= $signed(top));
      CondLtu:    cond_raw = (second < top);
      CondLeu:    cond_raw = (second <= top);
      CondZero:   cond_raw = (top == '0);
      default:    cond_raw = 1'b0;
    endcase
    cond_ok = cond_raw ^ flow.inv;
  end

  always_comb begin
    pc_d       = pc_plus1;
    taken_d    = 1'b0;
    fault_d    = fault_q;
    push       = 1'b0;
    pop        = 1'b0;
    clear_mask = '0;
    case (flow.kind)
      FlowBranch: begin
        if (cond_ok) begin
          pc_d    = pc_q + immediate;
          taken_d = 1'b1;
          if (flow.cond == CondInt && !flow.inv) clear_mask = pend_lowest;
        end
      end
      FlowJumpImm: begin
        pc_d    = immediate;
        taken_d = 1'b1;
      end
      FlowJumpStk: begin
        pc_d    = stk_target;
        taken_d = 1'b1;
      end
      FlowCallImm, FlowCallStk: begin
        if (stk_full) begin
          fault_d = 1'b1;
        end else begin
          push    = 1'b1;
          pc_d    = (flow.kind == FlowCallImm) ? immediate : stk_target;
          taken_d = 1'b1;
        end
      end
      FlowRet: begin
        if (stk_empty) begin
          fault_d = 1'b1;
        end else begin
          pop     = 1'b1;
          pc_d    = ret_addr;
          taken_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (stall) begin
      pc_d       = pc_q;
      taken_d    = taken_q;
      fault_d    = fault_q;
      push       = 1'b0;
      pop        = 1'b0;
      clear_mask = '0;
    end
    // A request arriving on the bit being cleared keeps it pending.
    pend_d = (pend_q & ~clear_mask) | interrupt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      taken_q <= 1'b0;
      fault_q <= 1'b0;
      pend_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      fault_q <= fault_d;
      pend_q  <= pend_d;
    end
  end

  return_stack #(
    .PC_WIDTH  (PC_WIDTH),
    .CALL_DEPTH(CALL_DEPTH)
  ) u_return_stack (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .push_data(pc_plus1),
    .top_data (ret_addr),
    .depth    (call_depth),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  assign pc          = pc_q;
  assign taken       = taken_q;
  assign int_pending = pend_q;
  assign stack_fault = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic against a queue-based model.
module tb_pc_sequencer;
  import core0_flow_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [7:0]  instruction;
  logic [15:0] immediate;
  logic [31:0] top, second;
  logic        carry, overflow;
  logic [3:0]  interrupt;
  logic [15:0] pc;
  logic        taken;
  logic [3:0]  call_depth;
  logic [3:0]  int_pending;
  logic        stack_fault;

  pc_sequencer #(
    .WORD_WIDTH(32),
    .PC_WIDTH  (16),
    .CALL_DEPTH(8),
    .INTERRUPTS(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .instruction(instruction),
    .immediate  (immediate),
    .top        (top),
    .second     (second),
    .carry      (carry),
    .overflow   (overflow),
    .interrupt  (interrupt),
    .pc         (pc),
    .taken      (taken),
    .call_depth (call_depth),
    .int_pending(int_pending),
    .stack_fault(stack_fault)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  logic [15:0] m_pc;
  logic [15:0] m_stk[$];
  logic [3:0]  m_pend;
  logic        m_taken, m_fault;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input string tag, input logic [7:0] op, input logic [15:0] imm,
                      input logic [31:0] t, input logic [31:0] s, input logic c,
                      input logic o, input logic [3:0] irq, input logic st, input logic rs);
    logic        is_br, cond;
    logic [15:0] nxt;
    logic        tk;
    logic [3:0]  clr;
    reset = rs; stall = st; instruction = op; immediate = imm;
    top = t; second = s; carry = c; overflow = o; interrupt = irq;
    is_br = 1'b1; cond = 1'b0; nxt = m_pc + 16'd1; tk = 1'b0; clr = 4'b0;
    case (op)
      I_BRA:   cond = 1'b1;
      I_BC:    cond = c;
      I_BNC:   cond = !c;
      I_BO:    cond = o;
      I_BNO:   cond = !o;
      I_BEQ:   cond = (t == s);
      I_BNE:   cond = (t != s);
      I_BLES:  cond = ($signed(s) < $signed(t));
      I_BLEQ:  cond = ($signed(s) <= $signed(t));
      I_BLESU: cond = (s < t);
      I_BLEQU: cond = (s <= t);
      I_BZ:    cond = (t == 0);
      I_BNZ:   cond = (t != 0);
      I_BI:    cond = (m_pend != 0);
      I_BNI:   cond = (m_pend == 0);
      default: is_br = 1'b0;
    endcase
    if (is_br && cond) begin
      nxt = m_pc + imm;
      tk  = 1'b1;
      if (op == I_BI) begin
        for (int i = 0; i < 4; i++) if (m_pend[i]) begin clr[i] = 1'b1; break; end
      end
    end else if (op == I_JMPI) begin
      nxt = imm; tk = 1'b1;
    end else if (op == I_JMP) begin
      nxt = t[15:0]; tk = 1'b1;
    end else if (op == I_CALLI || op == I_CALL) begin
      if (m_stk.size() == 8) begin
        if (!st && !rs) m_fault = 1'b1;
      end else begin
        if (!st && !rs) m_stk.push_back(m_pc + 16'd1);
        nxt = (op == I_CALLI) ? imm : t[15:0];
        tk  = 1'b1;
      end
    end else if (op == I_RET) begin
      if (m_stk.size() == 0) begin
        if (!st && !rs) m_fault = 1'b1;
      end else begin
        nxt = m_stk[m_stk.size()-1];
        if (!st && !rs) void'(m_stk.pop_back());
        tk  = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (rs) begin
      m_pc = 16'd0; m_taken = 1'b0; m_fault = 1'b0; m_pend = 4'd0;
      m_stk.delete();
    end else if (st) begin
      m_pend = m_pend | irq;
    end else begin
      m_pc = nxt; m_taken = tk;
      m_pend = (m_pend & ~clr) | irq;
    end
    check({tag, ".pc"}, 32'(pc), 32'(m_pc));
    check({tag, ".taken"}, 32'(taken), 32'(m_taken));
    check({tag, ".depth"}, 32'(call_depth), 32'(m_stk.size()));
    check({tag, ".pend"}, 32'(int_pending), 32'(m_pend));
    check({tag, ".fault"}, 32'(stack_fault), 32'(m_fault));
  endtask

  task automatic op1(input string tag, input logic [7:0] op, input logic [15:0] imm);
    step(tag, op, imm, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    step(tag, I_NOP, 16'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  logic [7:0] ops[24];

  initial begin
    m_pc = 16'd0; m_pend = 4'd0; m_taken = 1'b0; m_fault = 1'b0;
    ops = '{I_NOP, I_BRA, I_BC, I_BNC, I_BO, I_BNO, I_BEQ, I_BNE, I_BLES, I_BLEQ, I_BLESU,
            I_BLEQU, I_BZ, I_BNZ, I_BI, I_BNI, I_JMPI, I_JMP, I_CALLI, I_CALL, I_RET, I_RET,
            I_CALLI, 8'hFF};

    // 1: reset and sequential stepping
    do_reset("t1_rst");
    for (int i = 0; i < 3; i++) op1("t1_nop", I_NOP, 16'd0);
    check("t1_pc3", 32'(pc), 32'd3);

    // 2: relative branches with negative and signed comparisons
    op1("t2_jmpi", I_JMPI, 16'd10);
    step("t2_beq", I_BEQ, 16'hFFFC, 32'd5, 32'd5, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    check("t2_beq_pc", 32'(pc), 32'd6);
    check("t2_beq_taken", 32'(taken), 32'd1);
    step("t2_bles", I_BLES, 16'd2, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    check("t2_bles_pc", 32'(pc), 32'd8);

    // 3: call and return
    do_reset("t3_rst");
    for (int i = 0; i < 3; i++) op1("t3_nop", I_NOP, 16'd0);
    op1("t3_calli", I_CALLI, 16'h0100);
    check("t3_call_pc", 32'(pc), 32'h100);
    check("t3_call_depth", 32'(call_depth), 32'd1);
    op1("t3_ret", I_RET, 16'd0);
    check("t3_ret_pc", 32'(pc), 32'd4);
    check("t3_ret_depth", 32'(call_depth), 32'd0);

    // 4: overflow then underflow of the return stack
    do_reset("t4_rst");
    for (int i = 0; i < 9; i++) op1("t4_call", I_CALLI, 16'h0200);
    check("t4_ovf_pc", 32'(pc), 32'h201);
    check("t4_ovf_fault", 32'(stack_fault), 32'd1);
    check("t4_ovf_taken", 32'(taken), 32'd0);
    for (int i = 0; i < 9; i++) op1("t4_ret", I_RET, 16'd0);
    check("t4_unf_depth", 32'(call_depth), 32'd0);
    check("t4_unf_fault", 32'(stack_fault), 32'd1);
    check("t4_unf_taken", 32'(taken), 32'd0);

    // 5: interrupt pending and BI/BNI
    do_reset("t5_rst");
    step("t5_irq", I_NOP, 16'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0);
    op1("t5_bi1", I_BI, 16'd5);
    check("t5_bi1_pend", 32'(int_pending), 32'b0100);
    check("t5_bi1_taken", 32'(taken), 32'd1);
    step("t5_bi2", I_BI, 16'd5, 32'd0, 32'd0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0);
    check("t5_bi2_pend", 32'(int_pending), 32'b0100);
    op1("t5_bi3", I_BI, 16'd5);
    op1("t5_bni", I_BNI, 16'd3);
    check("t5_bni_taken", 32'(taken), 32'd1);

    // 6: stall holds everything but pending; reset mid call chain
    do_reset("t6_rst");
    op1("t6_nop", I_NOP, 16'd0);
    step("t6_st0", I_JMPI, 16'h55, 32'd0, 32'd0, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0);
    step("t6_st1", I_JMPI, 16'h55, 32'd0, 32'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    step("t6_st2", I_BI, 16'h55, 32'd0, 32'd0, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0);
    check("t6_stall_pc", 32'(pc), 32'd1);
    check("t6_stall_pend", 32'(int_pending), 32'b1001);
    op1("t6_go", I_JMPI, 16'h55);
    check("t6_go_pc", 32'(pc), 32'h55);
    op1("t6_c1", I_CALLI, 16'h300);
    op1("t6_c2", I_CALL, 16'h0);
    do_reset("t6_rst2");
    check("t6_rst_depth", 32'(call_depth), 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] t, s;
      logic [15:0] imm;
      t   = ($urandom_range(3) == 0) ? 32'($urandom_range(4)) : $urandom;
      s   = ($urandom_range(3) == 0) ? t : $urandom;
      imm = ($urandom_range(1) == 0) ? 16'($signed(8'($urandom))) : 16'($urandom);
      step("rnd", ops[$urandom_range(23)], imm, t, s, 1'($urandom), 1'($urandom),
           ($urandom_range(7) == 0) ? 4'($urandom) : 4'd0,
           $urandom_range(5) == 0, $urandom_range(199) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
